// File: rtl/add_subb_arb.sv
// Round-robin arbiter/sequencer sharing one add_subb among N requesters, one registered response slot.
// Optional ADD_SUBB_ARB_OVF_EN adds rsp_ovf_o, a registered signed-overflow flag.

module add_subb #(
  parameter int W = 4
) (
  input  logic         subb_a_i,
  input  logic         subb_b_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  logic [W-1:0] na_s;
  logic [W-1:0] nb_s;
  logic [W:0]   sum_s;

  // Negate in two's complement, then add; carry is bit W of the unsigned W-bit add
  always_comb begin
    na_s  = subb_a_i ? (~a_i + W'(1)) : a_i;
    nb_s  = subb_b_i ? (~b_i + W'(1)) : b_i;
    sum_s = {1'b0, na_s} + {1'b0, nb_s};
    s_o   = sum_s[W-1:0];
    c_o   = sum_s[W];
  end
endmodule

module add_subb_arb #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid_i,
  output logic [N-1:0]   req_ready_o,
  input  logic [N-1:0]   req_subb_a_i,
  input  logic [N-1:0]   req_subb_b_i,
  input  logic [N*W-1:0] req_a_i,
  input  logic [N*W-1:0] req_b_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [IDW-1:0] rsp_id_o,
  output logic [W-1:0]   rsp_s_o,
  output logic           rsp_c_o
`ifdef ADD_SUBB_ARB_OVF_EN
  ,
  output logic           rsp_ovf_o
`endif
);
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_s_q, rsp_s_d;
  logic           rsp_c_q, rsp_c_d;

  logic           slot_free_s;
  logic           found_s;
  logic [N-1:0]   grant_s;
  logic [IDW-1:0] gidx_s;
  logic [IDW:0]   idx_s;
  logic [W-1:0]   a_sel_s, b_sel_s;
  logic           sa_sel_s, sb_sel_s;
  logic [W-1:0]   sum_s;
  logic           carry_s;

  // Cyclic first-valid search starting at ptr; grant suppressed while in reset or slot busy
  always_comb begin
    slot_free_s = !rsp_valid_q || rsp_ready_i;
    grant_s     = '0;
    found_s     = 1'b0;
    gidx_s      = '0;
    idx_s       = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr_q} + (IDW+1)'(k);
      idx_s = (idx_s >= (IDW+1)'(N)) ? (idx_s - (IDW+1)'(N)) : idx_s;
      if (rst_n && slot_free_s && !found_s && req_valid_i[idx_s[IDW-1:0]]) begin
        found_s                      = 1'b1;
        gidx_s                       = idx_s[IDW-1:0];
        grant_s[idx_s[IDW-1:0]]      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    req_ready_o = grant_s;
  end

  // Operand mux for the granted requester
  always_comb begin
    a_sel_s  = req_a_i[gidx_s*W +: W];
    b_sel_s  = req_b_i[gidx_s*W +: W];
    sa_sel_s = req_subb_a_i[gidx_s];
    sb_sel_s = req_subb_b_i[gidx_s];
  end

  add_subb #(.W(W)) u_add_subb (
    .subb_a_i (sa_sel_s),
    .subb_b_i (sb_sel_s),
    .a_i      (a_sel_s),
    .b_i      (b_sel_s),
    .s_o      (sum_s),
    .c_o      (carry_s)
  );

`ifdef ADD_SUBB_ARB_OVF_EN
  logic [W+1:0] ea_s, eb_s, esum_s;
  logic         ovf_s;
  logic         rsp_ovf_q, rsp_ovf_d;

  // Exact signed sum in W+2 bits; overflow when the top three bits disagree
  always_comb begin
    ea_s   = {{2{a_sel_s[W-1]}}, a_sel_s};
    eb_s   = {{2{b_sel_s[W-1]}}, b_sel_s};
    ea_s   = sa_sel_s ? (~ea_s + (W+2)'(1)) : ea_s;
    eb_s   = sb_sel_s ? (~eb_s + (W+2)'(1)) : eb_s;
    esum_s = ea_s + eb_s;
    ovf_s  = !((esum_s[W+1:W-1] == 3'b000) || (esum_s[W+1:W-1] == 3'b111));
  end
`endif

  // Response slot and pointer next state: accept overwrites, drain clears valid only
  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_c_d     = rsp_c_q;
`ifdef ADD_SUBB_ARB_OVF_EN
    rsp_ovf_d   = rsp_ovf_q;
`endif
    if (found_s) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gidx_s;
      rsp_s_d     = sum_s;
      rsp_c_d     = carry_s;
`ifdef ADD_SUBB_ARB_OVF_EN
      rsp_ovf_d   = ovf_s;
`endif
      ptr_d       = (gidx_s == IDW'(N-1)) ? '0 : (gidx_s + IDW'(1));
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_c_q     <= 1'b0;
`ifdef ADD_SUBB_ARB_OVF_EN
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_c_q     <= rsp_c_d;
`ifdef ADD_SUBB_ARB_OVF_EN
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_s_o     = rsp_s_q;
  assign rsp_c_o     = rsp_c_q;
`ifdef ADD_SUBB_ARB_OVF_EN
  assign rsp_ovf_o   = rsp_ovf_q;
`endif
endmodule
